// File: rtl/alu_math_unit.sv
// Sequential integer math unit: POW, LOG2, ABS, MAX, MIN behind an ACT/ALU_RDY handshake.
// state | meaning
// IDLE  | ALU_RDY high, waiting for ACT
// CALC  | iterating square-and-multiply (POW) or doubling search (LOG2)
// DONE  | EX_ALU loaded, EX_ALU_VLD strobes on the way back to IDLE
module alu_math_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int RES_WIDTH  = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ACT,
  input  logic [2:0]            OP,
  input  logic [DATA_WIDTH-1:0] OPA,
  input  logic [DATA_WIDTH-1:0] OPB,
  output logic                  ALU_RDY,
  output logic [RES_WIDTH-1:0]  EX_ALU,
  output logic                  EX_ALU_VLD
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [2:0] OP_POW  = 3'd0;
  localparam logic [2:0] OP_LOG2 = 3'd1;
  localparam logic [2:0] OP_ABS  = 3'd2;
  localparam logic [2:0] OP_MAX  = 3'd3;
  localparam logic [2:0] OP_MIN  = 3'd4;
  localparam logic [DATA_WIDTH:0] M_ONE   = (DATA_WIDTH+1)'(1);
  localparam logic [RES_WIDTH-1:0] R_ONE  = RES_WIDTH'(1);

  state_t                  state;
  logic                    is_log2;
  logic [RES_WIDTH-1:0]    acc;
  logic [RES_WIDTH-1:0]    base;
  logic [DATA_WIDTH-1:0]   expo;
  logic [DATA_WIDTH-1:0]   n_val;
  logic [DATA_WIDTH:0]     m_cnt;

  logic signed [DATA_WIDTH-1:0] sa;
  logic signed [DATA_WIDTH-1:0] sb;
  logic [DATA_WIDTH-1:0]   abs_a;
  logic [RES_WIDTH-1:0]    ext_a;
  logic [RES_WIDTH-1:0]    ext_b;
  logic [RES_WIDTH-1:0]    ext_abs;
  logic [RES_WIDTH-1:0]    quick_res;
  logic                    go_calc;
  logic [RES_WIDTH-1:0]    acc_mul;
  logic [RES_WIDTH-1:0]    base_sq;
  logic [DATA_WIDTH-1:0]   expo_nxt;

  assign sa      = $signed(OPA);
  assign sb      = $signed(OPB);
  assign abs_a   = OPA[DATA_WIDTH-1] ? (~OPA + 1'b1) : OPA;
  assign ext_a   = {{(RES_WIDTH-DATA_WIDTH){OPA[DATA_WIDTH-1]}}, OPA};
  assign ext_b   = {{(RES_WIDTH-DATA_WIDTH){OPB[DATA_WIDTH-1]}}, OPB};
  // the most negative operand has no positive counterpart and stays negative
  assign ext_abs = {{(RES_WIDTH-DATA_WIDTH){abs_a[DATA_WIDTH-1]}}, abs_a};
  assign go_calc = ((OP == OP_POW) && (sb > 0)) || ((OP == OP_LOG2) && (sa > 1));

  always_comb begin
    quick_res = '0;
    case (OP)
      OP_POW:  quick_res = R_ONE;
      OP_ABS:  quick_res = ext_abs;
      OP_MAX:  quick_res = (sa >= sb) ? ext_a : ext_b;
      OP_MIN:  quick_res = (sa <= sb) ? ext_a : ext_b;
      default: quick_res = '0;
    endcase
  end

  assign acc_mul  = expo[0] ? (acc * base) : acc;
  assign base_sq  = base * base;
  assign expo_nxt = expo >> 1;
  assign ALU_RDY  = (state == IDLE);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= IDLE;
      is_log2    <= 1'b0;
      acc        <= '0;
      base       <= '0;
      expo       <= '0;
      n_val      <= '0;
      m_cnt      <= '0;
      EX_ALU     <= '0;
      EX_ALU_VLD <= 1'b0;
    end else begin
      EX_ALU_VLD <= 1'b0;
      case (state)
        IDLE: begin
          if (ACT) begin
            if (go_calc) begin
              state   <= CALC;
              is_log2 <= (OP == OP_LOG2);
              acc     <= (OP == OP_POW) ? R_ONE : '0;
              base    <= ext_a;
              expo    <= OPB;
              n_val   <= OPA;
              m_cnt   <= M_ONE;
            end else begin
              state  <= DONE;
              EX_ALU <= quick_res;
            end
          end
        end
        CALC: begin
          if (is_log2) begin
            if (m_cnt < {1'b0, n_val}) begin
              m_cnt <= m_cnt << 1;
              acc   <= acc + R_ONE;
            end else begin
              state  <= DONE;
              EX_ALU <= acc;
            end
          end else begin
            acc  <= acc_mul;
            base <= base_sq;
            expo <= expo_nxt;
            if (expo_nxt == '0) begin
              state  <= DONE;
              EX_ALU <= acc_mul;
            end
          end
        end
        DONE: begin
          EX_ALU_VLD <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_math_unit.sv
// Randomized and directed bench for alu_math_unit against an arithmetic reference model.
module tb_alu_math_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ACT;
  logic [2:0]  OP;
  logic [31:0] OPA;
  logic [31:0] OPB;
  logic        ALU_RDY;
  logic [63:0] EX_ALU;
  logic        EX_ALU_VLD;

  alu_math_unit #(.DATA_WIDTH(32), .RES_WIDTH(64)) dut (
    .CLK(CLK), .RST(RST), .ACT(ACT), .OP(OP), .OPA(OPA), .OPB(OPB),
    .ALU_RDY(ALU_RDY), .EX_ALU(EX_ALU), .EX_ALU_VLD(EX_ALU_VLD)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [63:0] last_res = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: results straight from the arithmetic definitions.
  function automatic void model(input logic [2:0] op, input int a, input int b,
                                output logic [63:0] res, output int lat);
    longint p;
    int     t;
    int     nb;
    res = '0;
    lat = 1;
    case (op)
      3'd0: begin
        if (b <= 0) res = 64'd1;
        else begin
          if (a == 1) p = 1;
          else if (a == 0) p = 0;
          else if (a == -1) p = b[0] ? -64'sd1 : 64'sd1;
          else if (!a[0] && b >= 64) p = 0;
          else begin
            p = 1;
            for (int i = 0; i < b; i++) p = p * longint'(a);
          end
          res = p;
          nb = 0;
          t = b;
          while (t > 0) begin nb++; t = t >>> 1; end
          lat = nb + 1;
        end
      end
      3'd1: begin
        if (a > 1) begin
          t = 0;
          while ((longint'(1) << t) < longint'(a)) t++;
          res = 64'(t);
          lat = t + 2;
        end
      end
      3'd2: begin
        t = (a < 0) ? -a : a;
        res = longint'(t);
      end
      3'd3: res = (a >= b) ? longint'(a) : longint'(b);
      3'd4: res = (a <= b) ? longint'(a) : longint'(b);
      default: res = '0;
    endcase
  endfunction

  // Results and latencies are checked whenever they are meaningful.
  always @(negedge CLK) begin
    if (!RST) last_res = '0;
    else if (EX_ALU_VLD) begin
      if (q.size() == 0) chk("unexpected_vld", {63'b0, EX_ALU_VLD}, 64'd0);
      else begin
        mon_e = q.pop_front();
        chk("result", EX_ALU, mon_e.res);
        chk("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
        last_res = mon_e.res;
      end
    end else if (q.size() == 0) begin
      chk("idle_rdy", {63'b0, ALU_RDY}, 64'd1);
      chk("hold_ex_alu", EX_ALU, last_res);
    end
  end

  // Called at a negedge; returns at a negedge.
  task automatic send(input logic [2:0] op, input int a, input int b, input bit wait_done);
    exp_t e;
    int   k;
    k = 0;
    while (!ALU_RDY && k < 200) begin @(negedge CLK); k++; end
    if (!ALU_RDY) begin
      chk("rdy_timeout", {63'b0, ALU_RDY}, 64'd1);
      return;
    end
    OP = op; OPA = a; OPB = b; ACT = 1'b1;
    model(op, a, b, e.res, e.lat);
    @(posedge CLK);
    #1;
    e.acc = cyc;
    q.push_back(e);
    @(negedge CLK);
    ACT = 1'b0;
    OP  = 3'($urandom);
    OPA = $urandom;
    OPB = $urandom;
    if (wait_done) begin
      k = 0;
      while (q.size() != 0 && k < 300) begin @(negedge CLK); k++; end
      if (q.size() != 0) begin
        chk("vld_timeout", 64'(q.size()), 64'd0);
        q.delete();
      end
    end
  endtask

  task automatic pin(input string nm, input logic [2:0] op, input int a, input int b,
                     input logic [63:0] er, input int el);
    logic [63:0] r;
    int          l;
    model(op, a, b, r, l);
    chk({nm, "_model"}, r, er);
    chk({nm, "_model_lat"}, 64'(l), 64'(el));
    send(op, a, b, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int b;
    logic [2:0] op;
    RST = 1'b0; ACT = 1'b0; OP = '0; OPA = '0; OPB = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ex_alu", EX_ALU, 64'd0);
    chk("rst_rdy", {63'b0, ALU_RDY}, 64'd1);
    chk("rst_vld", {63'b0, EX_ALU_VLD}, 64'd0);
    RST = 1'b1;
    @(negedge CLK);

    pin("pow3_5",    3'd0, 3, 5, 64'd243, 4);
    pin("pow_m2_3",  3'd0, -2, 3, 64'hFFFF_FFFF_FFFF_FFF8, 3);
    pin("pow7_m1",   3'd0, 7, -1, 64'd1, 1);
    pin("pow7_0",    3'd0, 7, 0, 64'd1, 1);
    pin("pow2_64",   3'd0, 2, 64, 64'd0, 8);
    pin("pow_max_2", 3'd0, 32'h7FFF_FFFF, 2, 64'h3FFF_FFFF_0000_0001, 3);
    pin("pow1_big",  3'd0, 1, 32'h7FFF_FFFF, 64'd1, 32);
    pin("powm1_big", 3'd0, -1, 32'h7FFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 32);
    pin("log2_1000", 3'd1, 1000, 0, 64'd10, 12);
    pin("log2_8",    3'd1, 8, 0, 64'd3, 5);
    pin("log2_0",    3'd1, 0, 0, 64'd0, 1);
    pin("log2_1",    3'd1, 1, 0, 64'd0, 1);
    pin("log2_m5",   3'd1, -5, 0, 64'd0, 1);
    pin("log2_max",  3'd1, 32'h7FFF_FFFF, 0, 64'd31, 33);
    pin("abs_min",   3'd2, 32'h8000_0000, 0, 64'hFFFF_FFFF_8000_0000, 1);
    pin("abs_m7",    3'd2, -7, 0, 64'd7, 1);
    pin("max",       3'd3, -3, 2, 64'd2, 1);
    pin("min",       3'd4, -3, 2, 64'hFFFF_FFFF_FFFF_FFFD, 1);
    pin("max_tie",   3'd3, 4, 4, 64'd4, 1);
    pin("undef",     3'd7, 5, 6, 64'd0, 1);

    // ACT held while busy must not start a second operation
    send(3'd0, 3, 5, 1'b0);
    while (!ALU_RDY) begin
      OP = 3'd0; OPA = 2; OPB = 20; ACT = 1'b1;
      @(negedge CLK);
    end
    ACT = 1'b0;
    repeat (30) @(negedge CLK);
    chk("busy_ignored", 64'(q.size()), 64'd0);

    // back-to-back: second request accepted the cycle ALU_RDY returns
    send(3'd1, 1000, 0, 1'b0);
    send(3'd3, -8, 17, 1'b0);
    send(3'd0, -3, 7, 1'b1);

    // reset in the middle of CALC
    send(3'd0, 3, 32'h0000_7FFF, 1'b0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1;
    q.delete();
    @(negedge CLK);
    chk("midrst_ex_alu", EX_ALU, 64'd0);
    chk("midrst_rdy", {63'b0, ALU_RDY}, 64'd1);
    chk("midrst_vld", {63'b0, EX_ALU_VLD}, 64'd0);
    RST = 1'b1;
    repeat (40) @(negedge CLK);
    pin("max_1_9", 3'd3, 1, 9, 64'd9, 1);

    for (int i = 0; i < 120; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if (op == 3'd0) begin
        if ($urandom_range(0, 1) == 1) a = int'($urandom_range(0, 20)) - 10;
        b = int'($urandom_range(0, 43)) - 3;
      end else if (op == 3'd1 && $urandom_range(0, 1) == 1) begin
        a = int'($urandom_range(0, 2000)) - 5;
      end else if ($urandom_range(0, 3) == 0) begin
        b = a;
      end
      send(op, a, b, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
    begin
      int k;
      k = 0;
      while (q.size() != 0 && k < 300) begin @(negedge CLK); k++; end
      chk("final_drain", 64'(q.size()), 64'd0);
    end
    repeat (3) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
